// File: rtl/pixel_write_sink.sv
// Buffers drawer pixels in a small FIFO ahead of the framebuffer write port.
// Out-of-range pixels are clipped and counted; in-range pixels lost to a full FIFO set overflow.
module pixel_write_sink #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned X_MAX = 159,
  parameter int unsigned Y_MAX = 119
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  x_in,
  input  logic [6:0]  y_in,
  input  logic [2:0]  colour_in,
  input  logic        write_in,
  output logic        full,
  output logic [7:0]  x_out,
  output logic [6:0]  y_out,
  output logic [2:0]  colour_out,
  output logic        write_out,
  input  logic        mem_ready,
  output logic        overflow,
  output logic [7:0]  clip_count,
  output logic [15:0] pixel_count,
  output logic        idle
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);
  localparam logic [7:0]  XMax = X_MAX[7:0];
  localparam logic [6:0]  YMax = Y_MAX[6:0];

  logic [17:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q;
  logic [7:0]    clip_count_q;
  logic [15:0]   pixel_count_q;

  logic in_range;
  logic push;
  logic pop;
  logic [17:0] head;

  assign in_range  = (x_in <= XMax) && (y_in <= YMax);
  assign full      = (count_q == FullCount);
  assign write_out = (count_q != '0);
  // Both conditions use pre-edge occupancy, so a pop never frees room for a same-edge push.
  assign push      = write_in && in_range && !full;
  assign pop       = write_out && mem_ready;

  assign head       = write_out ? mem_q[rd_ptr_q] : 18'd0;
  assign x_out      = head[17:10];
  assign y_out      = head[9:3];
  assign colour_out = head[2:0];

  assign idle        = !write_out && !write_in;
  assign overflow    = overflow_q;
  assign clip_count  = clip_count_q;
  assign pixel_count = pixel_count_q;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
      clip_count_q  <= '0;
      pixel_count_q <= '0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q      <= rd_ptr_q + 1'b1;
        pixel_count_q <= pixel_count_q + 16'd1;
      end
      if (write_in && in_range && full) overflow_q <= 1'b1;
      if (write_in && !in_range && (clip_count_q != 8'hff)) clip_count_q <= clip_count_q + 8'd1;
    end
  end

  // Storage needs no reset; entries are only visible through the occupancy count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {x_in, y_in, colour_in};
  end

endmodule

// File: tb/tb_pixel_write_sink.sv
// Directed bench for pixel_write_sink: a scoreboard queue of expected pixels, drained by a
// monitor whenever the DUT hands a pixel to the framebuffer.
module tb_pixel_write_sink;

  logic        clk = 1'b0;
  logic        resetn;
  logic [7:0]  x_in;
  logic [6:0]  y_in;
  logic [2:0]  colour_in;
  logic        write_in;
  logic        full;
  logic [7:0]  x_out;
  logic [6:0]  y_out;
  logic [2:0]  colour_out;
  logic        write_out;
  logic        mem_ready;
  logic        overflow;
  logic [7:0]  clip_count;
  logic [15:0] pixel_count;
  logic        idle;

  int n_checks = 0;
  int n_errors = 0;
  logic [17:0] sb[$];

  pixel_write_sink #(.DEPTH(8), .X_MAX(159), .Y_MAX(119)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .x_in        (x_in),
    .y_in        (y_in),
    .colour_in   (colour_in),
    .write_in    (write_in),
    .full        (full),
    .x_out       (x_out),
    .y_out       (y_out),
    .colour_out  (colour_out),
    .write_out   (write_out),
    .mem_ready   (mem_ready),
    .overflow    (overflow),
    .clip_count  (clip_count),
    .pixel_count (pixel_count),
    .idle        (idle)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one pixel for the next edge; exp says whether it should be accepted.
  task automatic drive(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c,
                       input bit exp);
    x_in      = x;
    y_in      = y;
    colour_in = c;
    write_in  = 1'b1;
    if (exp) sb.push_back({x, y, c});
  endtask

  // Monitor: a pixel is delivered at the next edge whenever write_out and mem_ready are high.
  always @(negedge clk) begin
    if (resetn && write_out && mem_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_pixel: got x=%0d y=%0d c=%0d, expected none",
                 x_out, y_out, colour_out);
      end else begin
        logic [17:0] e;
        e = sb.pop_front();
        check("pixel_order", {14'd0, x_out, y_out, colour_out}, {14'd0, e});
      end
    end
  end

  task automatic do_reset();
    resetn    = 1'b0;
    write_in  = 1'b0;
    mem_ready = 1'b0;
    tick();
    tick();
    sb.delete();
    resetn = 1'b1;
  endtask

  initial begin
    x_in = '0; y_in = '0; colour_in = '0;
    do_reset();
    check("rst_write_out", write_out, 0);
    check("rst_full", full, 0);
    check("rst_overflow", overflow, 0);
    check("rst_clip", clip_count, 0);
    check("rst_pixels", pixel_count, 0);
    check("rst_idle", idle, 1);
    check("rst_head", {x_out, y_out, colour_out}, 0);

    // Single pixel.
    mem_ready = 1'b1;
    drive(8'd23, 7'd3, 3'd7, 1);
    tick();
    write_in = 1'b0;
    check("single_valid", write_out, 1);
    check("single_x", x_out, 23);
    check("single_y", y_out, 3);
    check("single_c", colour_out, 7);
    check("single_busy", idle, 0);
    tick();
    check("single_one_cycle", write_out, 0);
    check("single_count", pixel_count, 1);
    check("single_idle", idle, 1);

    // Fill, overflow, drain.
    mem_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive(8'(10 + i), 7'(i), 3'(i), i < 8);
      tick();
      if (i == 6) check("not_full_at_7", full, 0);
      if (i == 7) begin
        check("full_at_8", full, 1);
        check("no_overflow_yet", overflow, 0);
      end
    end
    write_in = 1'b0;
    check("full_after_9", full, 1);
    check("overflow_set", overflow, 1);
    check("head_stable", x_out, 10);
    mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    check("drained", write_out, 0);
    check("drain_count", pixel_count, 9);
    check("overflow_sticky", overflow, 1);

    // Clipping.
    drive(8'd160, 7'd0, 3'd1, 0);
    tick();
    drive(8'd0, 7'd120, 3'd2, 0);
    tick();
    drive(8'd159, 7'd119, 3'd5, 1);
    tick();
    write_in = 1'b0;
    tick();
    check("clip_count", clip_count, 2);
    check("clip_delivered", pixel_count, 10);

    // Streaming with simultaneous push and pop.
    do_reset();
    mem_ready = 1'b1;
    for (int i = 0; i < 114; i++) begin
      drive(8'(23 + i), 7'd40, 3'(i), 1);
      tick();
      check("stream_valid", write_out, 1);
    end
    write_in = 1'b0;
    tick();
    check("stream_occ_le1", write_out, 0);
    check("stream_count", pixel_count, 114);

    // Counter saturation and wrap.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      drive(8'd200, 7'd5, 3'd0, 0);
      tick();
    end
    write_in = 1'b0;
    check("clip_saturate", clip_count, 255);
    check("clip_nothing_buffered", write_out, 0);
    mem_ready = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      drive(8'(i % 160), 7'((i / 160) % 120), 3'(i), 1);
      tick();
    end
    write_in = 1'b0;
    tick();
    check("pixel_wrap", pixel_count, 1);
    check("clip_held", clip_count, 255);

    // Reset mid-stream with 5 entries buffered and overflow set.
    mem_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive(8'(50 + i), 7'(60 + i), 3'(7 - i), i < 8);
      tick();
    end
    write_in = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    mem_ready = 1'b0;
    check("pre_reset_overflow", overflow, 1);
    check("pre_reset_valid", write_out, 1);
    check("pre_reset_head", x_out, 53);
    resetn = 1'b0;
    tick();
    sb.delete();
    check("mid_rst_write_out", write_out, 0);
    check("mid_rst_overflow", overflow, 0);
    check("mid_rst_full", full, 0);
    check("mid_rst_clip", clip_count, 0);
    check("mid_rst_pixels", pixel_count, 0);
    check("mid_rst_idle", idle, 1);
    check("mid_rst_head", {x_out, y_out, colour_out}, 0);
    resetn = 1'b1;
    mem_ready = 1'b1;
    tick();
    check("post_rst_no_pulse", write_out, 0);
    check("post_rst_pixels", pixel_count, 0);

    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
